dcache_repair_responder: RTL and testbench
==========================================

DCACHE_REPAIR_RESPONDER -- requirements
Module: dcache_repair_responder

Interface
REQ-001 Parameter BLOCK_BITS, default 1024, cache block width in bits.
REQ-002 Parameter WORD_BITS, default 32, memory beat width in bits.
REQ-003 Parameter BEATS, default BLOCK_BITS/WORD_BITS (32), beats per block fill.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low.
REQ-006 read_repair_request  input  1  controller miss request; held high until repair_resolved is seen.
REQ-007 missed_addr  input  32  byte address of the miss; valid while read_repair_request is high.
REQ-008 wdata  output  BLOCK_BITS  assembled repair block.
REQ-009 waddr  output  32  block-aligned repair address.
REQ-010 waddr_valid  output  1  wdata/waddr/wmask are valid this cycle.
REQ-011 wmask  output  BLOCK_BITS/8  byte write mask.
REQ-012 sent_repair  output  1  repair block presented this cycle.
REQ-013 repair_resolved  output  1  repair transaction complete, one-cycle pulse.
REQ-014 mem_req_valid  output  1  memory read request valid.
REQ-015 mem_req_addr  output  32  word address of the memory read.
REQ-016 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-017 mem_resp_valid  input  1  memory read data valid; responses return in request order.
REQ-018 mem_resp_data  input  WORD_BITS  memory read data.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, SEND, RESOLVE, DONE.
REQ-020 IDLE with read_repair_request=1: latch base = {missed_addr[31:7], 7'b0}, clear both counters and the buffer, go to FETCH next cycle.
REQ-021 FETCH: mem_req_valid=1 while issue_cnt<BEATS; mem_req_addr = base + 4*issue_cnt; issue_cnt increments only when mem_req_valid&&mem_req_ready.
REQ-022 FETCH: each mem_resp_valid stores mem_resp_data into word slot recv_cnt (bits [WORD_BITS*recv_cnt +: WORD_BITS]) and increments recv_cnt; word i always comes from base+4*i.
REQ-023 mem_resp_valid SHALL be ignored when recv_cnt==issue_cnt (no outstanding request) or outside FETCH.
REQ-024 Issue and receive SHALL overlap; request and response in the same cycle both take effect.
REQ-025 FETCH -> SEND on the cycle recv_cnt reaches BEATS (last response accepted).
REQ-026 SEND, exactly one cycle: waddr_valid=1, sent_repair=1, waddr=base, wmask=all ones, wdata=assembled block.
REQ-027 SEND -> RESOLVE; RESOLVE asserts repair_resolved=1 for exactly one cycle, then -> DONE.
REQ-028 DONE lasts one cycle with read_repair_request ignored, then -> IDLE, so a request still held during the resolve handshake is not re-serviced.
REQ-029 Outside SEND, waddr_valid, sent_repair and wmask SHALL be 0; wdata and waddr hold their last values.
REQ-030 Counters SHALL be $clog2(BEATS)+1 bits wide and SHALL never exceed BEATS; no wrap.
REQ-031 Changes of missed_addr after latching SHALL have no effect until the next IDLE acceptance.
REQ-032 Best-case latency: request seen in IDLE -> sent_repair asserted BEATS+2 cycles later when memory is always ready with one-cycle read latency.

Reset
REQ-033 rst low SHALL immediately force state IDLE, counters 0, and all outputs 0 (wdata, waddr, wmask included), including mid-fill; a fill in progress is abandoned.
REQ-034 The first IDLE acceptance after rst deasserts SHALL be on the first rising edge with rst high.

Structure
REQ-035 CORE_PKG SHALL hold BLOCK_BITS, WORD_BITS, BEATS, the block-offset width (7) and the FSM state enum type.
REQ-036 Block assembly SHALL be one sub-module, dcache_fill_buffer: slot-indexed word write, clear, full-block read.

Verification
REQ-037 Always-ready memory with 1-cycle latency, missed_addr=32'hAABB_CCDD -> mem_req_addr sequence 32'hAABB_CC80..32'hAABB_CCFC; waddr=32'hAABB_CC80; wdata word i = 32'h1000_0000+i; sent_repair pulse at BEATS+2 cycles.
REQ-038 mem_req_ready low on every other cycle, responses delayed 3 cycles -> identical wdata; sent_repair and repair_resolved each high exactly one cycle, back to back.
REQ-039 read_repair_request held for 2 cycles after repair_resolved -> no new mem_req_valid; a fresh request after DONE starts a new fill.
REQ-040 Spurious mem_resp_valid in IDLE and with zero outstanding requests -> no buffer change, recv_cnt unchanged.
REQ-041 rst asserted after beat 10 of a fill -> all outputs 0 at once; new request for 32'h0000_1004 -> fill from 32'h0000_1000 with correct data.
REQ-042 missed_addr changed to 32'h1234_5678 mid-FETCH -> fill and waddr remain on the originally latched base.

Source files
------------

// File: rtl/dcache_repair_responder_pkg.sv
// Shared geometry, FSM state type and address helper for the data-cache repair responder.
package dcache_repair_responder_pkg;

    localparam int BLOCK_BITS   = 1024;
    localparam int WORD_BITS    = 32;
    localparam int BEATS        = BLOCK_BITS / WORD_BITS;
    localparam int BLK_OFF_BITS = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SEND    = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    function automatic logic [31:0] block_align(input logic [31:0] addr);
        return {addr[31:BLK_OFF_BITS], {BLK_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_fill_buffer.sv
// Word-slot fill buffer; block_nx exposes the contents including this cycle's clear/write.
module dcache_fill_buffer
    import dcache_repair_responder_pkg::*;
#(
    parameter int WORD_BITS = dcache_repair_responder_pkg::WORD_BITS,
    parameter int BEATS     = dcache_repair_responder_pkg::BEATS,
    parameter int SLOT_W    = $clog2(dcache_repair_responder_pkg::BEATS) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [SLOT_W-1:0]          slot,
    input  logic [WORD_BITS-1:0]       wr_data,
    output logic [WORD_BITS*BEATS-1:0] block_nx
);

    logic [WORD_BITS*BEATS-1:0] block_r;

    // Next buffer contents: clear wins, otherwise only the addressed slot changes.
    always_comb begin
        block_nx = block_r;
        for (int i = 0; i < BEATS; i++) begin
            block_nx[i*WORD_BITS +: WORD_BITS] = clr ? {WORD_BITS{1'b0}} :
                ((wr_en && (slot == SLOT_W'(i))) ? wr_data : block_r[i*WORD_BITS +: WORD_BITS]);
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            block_r <= {(WORD_BITS*BEATS){1'b0}};
        end else begin
            block_r <= block_nx;
        end
    end

endmodule

// File: rtl/dcache_repair_responder.sv
// Services a cache-miss repair: fetches one block beat by beat, presents it once, then resolves.
module dcache_repair_responder
    import dcache_repair_responder_pkg::*;
#(
    parameter int BLOCK_BITS = dcache_repair_responder_pkg::BLOCK_BITS,
    parameter int WORD_BITS  = dcache_repair_responder_pkg::WORD_BITS,
    parameter int BEATS      = BLOCK_BITS / WORD_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read_repair_request,
    input  logic [31:0]             missed_addr,
    output logic [BLOCK_BITS-1:0]   wdata,
    output logic [31:0]             waddr,
    output logic                    waddr_valid,
    output logic [BLOCK_BITS/8-1:0] wmask,
    output logic                    sent_repair,
    output logic                    repair_resolved,
    output logic                    mem_req_valid,
    output logic [31:0]             mem_req_addr,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [WORD_BITS-1:0]    mem_resp_data
);

    localparam int               CNT_W   = $clog2(BEATS) + 1;
    localparam int               MASK_W  = BLOCK_BITS / 8;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_e                  state_r, state_nx;
    logic [CNT_W-1:0]        issue_cnt_r, issue_nx;
    logic [CNT_W-1:0]        recv_cnt_r, recv_nx;
    logic [31:0]             base_r, base_nx;
    logic                    buf_clr_s;
    logic                    issue_fire_s;
    logic                    resp_fire_s;
    logic [BLOCK_BITS-1:0]   buf_nx_s;

    logic [BLOCK_BITS-1:0]   wdata_r;
    logic [31:0]             waddr_r;
    logic                    waddr_valid_r;
    logic [MASK_W-1:0]       wmask_r;
    logic                    sent_repair_r;
    logic                    repair_resolved_r;
    logic                    mem_req_valid_r;
    logic [31:0]             mem_req_addr_r;

    // A response only counts against an outstanding request, so recv_cnt can never pass issue_cnt.
    assign issue_fire_s = mem_req_valid_r && mem_req_ready;
    assign resp_fire_s  = (state_r == ST_FETCH) && mem_resp_valid && (recv_cnt_r != issue_cnt_r);

    dcache_fill_buffer #(
        .WORD_BITS (WORD_BITS),
        .BEATS     (BEATS),
        .SLOT_W    (CNT_W)
    ) u_fill_buffer (
        .clk      (clk),
        .rst      (rst),
        .clr      (buf_clr_s),
        .wr_en    (resp_fire_s),
        .slot     (recv_cnt_r),
        .wr_data  (mem_resp_data),
        .block_nx (buf_nx_s)
    );

    // Next-state, counter and base-address logic.
    always_comb begin
        state_nx  = state_r;
        issue_nx  = issue_cnt_r;
        recv_nx   = recv_cnt_r;
        base_nx   = base_r;
        buf_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read_repair_request) begin
                    base_nx   = block_align(missed_addr);
                    issue_nx  = {CNT_W{1'b0}};
                    recv_nx   = {CNT_W{1'b0}};
                    buf_clr_s = 1'b1;
                    state_nx  = ST_FETCH;
                end else begin
                    state_nx  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                issue_nx = issue_fire_s ? (issue_cnt_r + ONE_C) : issue_cnt_r;
                recv_nx  = resp_fire_s ? (recv_cnt_r + ONE_C) : recv_cnt_r;
                state_nx = (recv_nx == BEATS_C) ? ST_SEND : ST_FETCH;
            end
            ST_SEND:    state_nx = ST_RESOLVE;
            ST_RESOLVE: state_nx = ST_DONE;
            // DONE ignores the request so one still held from the handshake is not re-serviced.
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            issue_cnt_r <= {CNT_W{1'b0}};
            recv_cnt_r  <= {CNT_W{1'b0}};
            base_r      <= 32'd0;
        end else begin
            state_r     <= state_nx;
            issue_cnt_r <= issue_nx;
            recv_cnt_r  <= recv_nx;
            base_r      <= base_nx;
        end
    end

    // Registered outputs, computed from next-state values so they line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdata_r           <= {BLOCK_BITS{1'b0}};
            waddr_r           <= 32'd0;
            waddr_valid_r     <= 1'b0;
            wmask_r           <= {MASK_W{1'b0}};
            sent_repair_r     <= 1'b0;
            repair_resolved_r <= 1'b0;
            mem_req_valid_r   <= 1'b0;
            mem_req_addr_r    <= 32'd0;
        end else begin
            waddr_valid_r     <= (state_nx == ST_SEND);
            sent_repair_r     <= (state_nx == ST_SEND);
            wmask_r           <= (state_nx == ST_SEND) ? {MASK_W{1'b1}} : {MASK_W{1'b0}};
            repair_resolved_r <= (state_nx == ST_RESOLVE);
            mem_req_valid_r   <= (state_nx == ST_FETCH) && (issue_nx < BEATS_C);
            mem_req_addr_r    <= base_nx + 32'({issue_nx, 2'b00});
            if (state_nx == ST_SEND) begin
                wdata_r <= buf_nx_s;
                waddr_r <= base_nx;
            end else begin
                wdata_r <= wdata_r;
                waddr_r <= waddr_r;
            end
        end
    end

    assign wdata           = wdata_r;
    assign waddr           = waddr_r;
    assign waddr_valid     = waddr_valid_r;
    assign wmask           = wmask_r;
    assign sent_repair     = sent_repair_r;
    assign repair_resolved = repair_resolved_r;
    assign mem_req_valid   = mem_req_valid_r;
    assign mem_req_addr    = mem_req_addr_r;

endmodule

// File: tb/tb_dcache_repair_responder.sv
// Directed bench for dcache_repair_responder with a behavioural memory and scoreboard queues.
module tb_dcache_repair_responder;
    import dcache_repair_responder_pkg::*;

    localparam int BB = BLOCK_BITS;
    localparam int WB = WORD_BITS;
    localparam int NB = BEATS;

    typedef struct {
        logic [31:0]   addr;
        logic [BB-1:0] data;
    } exp_blk_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic            clk;
    logic            rst;
    logic            read_repair_request;
    logic [31:0]     missed_addr;
    logic [BB-1:0]   wdata;
    logic [31:0]     waddr;
    logic            waddr_valid;
    logic [BB/8-1:0] wmask;
    logic            sent_repair;
    logic            repair_resolved;
    logic            mem_req_valid;
    logic [31:0]     mem_req_addr;
    logic            mem_req_ready  = 1'b0;
    logic            mem_resp_valid = 1'b0;
    logic [WB-1:0]   mem_resp_data  = 32'd0;
    logic            resp_from_q    = 1'b0;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          ready_mode = 0;
    logic        spur     = 1'b0;
    logic [31:0] salt     = 32'h1000_0000;
    int          resp_cnt = 0;
    int          sent_cyc = 0;
    int          req_cyc  = 0;
    int          n_sent   = 0;
    int          n_resolved = 0;
    logic        prev_sent = 1'b0;

    mreq_t       mem_q[$];
    logic [31:0] exp_addr_q[$];
    exp_blk_t    exp_blk_q[$];

    dcache_repair_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .read_repair_request (read_repair_request),
        .missed_addr         (missed_addr),
        .wdata               (wdata),
        .waddr               (waddr),
        .waddr_valid         (waddr_valid),
        .wmask               (wmask),
        .sent_repair         (sent_repair),
        .repair_resolved     (repair_resolved),
        .mem_req_valid       (mem_req_valid),
        .mem_req_addr        (mem_req_addr),
        .mem_req_ready       (mem_req_ready),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_data       (mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int first_bad(input logic [BB-1:0] a, input logic [BB-1:0] b);
        for (int i = 0; i < NB; i++) begin
            if (a[i*WB +: WB] !== b[i*WB +: WB]) return i;
        end
        return -1;
    endfunction

    task automatic check_wdata(input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        int bad;
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            bad = first_bad(obs, exp);
            $error("FAIL wdata: word %0d observed %h expected %h", bad,
                   obs[((bad < 0) ? 0 : bad)*WB +: WB], exp[((bad < 0) ? 0 : bad)*WB +: WB]);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wdata"},        64'(|wdata), 64'd0);
        check({tag, "_waddr"},        64'(waddr), 64'd0);
        check({tag, "_wmask"},        64'(|wmask), 64'd0);
        check({tag, "_strobes"},      64'({waddr_valid, sent_repair, repair_resolved, mem_req_valid}), 64'd0);
        check({tag, "_mem_req_addr"}, 64'(mem_req_addr), 64'd0);
    endtask

    // Push the expected request addresses and block, then raise the request.
    task automatic start_fill(input logic [31:0] addr);
        exp_blk_t    e;
        logic [31:0] b;
        b = {addr[31:7], 7'd0};
        for (int i = 0; i < NB; i++) begin
            exp_addr_q.push_back(b + 32'(4 * i));
            e.data[i*WB +: WB] = salt + 32'(i);
        end
        e.addr = b;
        exp_blk_q.push_back(e);
        missed_addr         = addr;
        read_repair_request = 1'b1;
        req_cyc             = cyc;
    endtask

    // Wait (bounded) for the resolve pulse, keep the request through hold extra edges, then drop it.
    task automatic finish_fill(input int hold);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = repair_resolved;
        end
        check("resolved_seen", 64'(found), 64'd1);
        repeat (hold + 1) @(posedge clk);
        #1;
        read_repair_request = 1'b0;
    endtask

    // Memory: in-order responses lat cycles after acceptance, optional spurious beats when idle.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        if (mem_resp_valid && resp_from_q && (mem_q.size() > 0)) begin
            void'(mem_q.pop_front());
            resp_cnt++;
        end
        if (mem_req_valid && mem_req_ready) mem_q.push_back('{mem_req_addr, cyc + lat - 1});
        #1;
        mem_req_ready = (ready_mode == 0) ? 1'b1 : ((ready_mode == 1) ? cyc[0] : 1'b0);
        if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = salt + {27'd0, mem_q[0].addr[6:2]};
            resp_from_q    = 1'b1;
        end else if (spur) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_BEEF;
            resp_from_q    = 1'b0;
        end else begin
            mem_resp_valid = 1'b0;
            resp_from_q    = 1'b0;
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            check("req_expected", 64'(exp_addr_q.size() != 0), 64'd1);
            if (exp_addr_q.size() != 0) check("mem_req_addr", 64'(mem_req_addr), 64'(exp_addr_q.pop_front()));
        end
        if (sent_repair) begin
            exp_blk_t e;
            sent_cyc = cyc;
            n_sent++;
            check("blk_expected", 64'(exp_blk_q.size() != 0), 64'd1);
            if (exp_blk_q.size() != 0) begin
                e = exp_blk_q.pop_front();
                check("waddr", 64'(waddr), 64'(e.addr));
                check("send_strobes", 64'({waddr_valid, &wmask}), 64'd3);
                check_wdata(wdata, e.data);
            end
        end else begin
            check("idle_strobes", 64'({waddr_valid, |wmask}), 64'd0);
        end
        if (repair_resolved) n_resolved++;
        check("resolved_after_sent", 64'(repair_resolved), 64'(prev_sent));
        prev_sent = sent_repair;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        int base_resp;
        logic found;

        rst                 = 1'b0;
        read_repair_request = 1'b0;
        missed_addr         = 32'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Always-ready, 1-cycle memory; request held one extra edge (through DONE).
        @(posedge clk);
        #1;
        start_fill(32'hAABB_CCDD);
        finish_fill(1);
        check("latency", 64'(sent_cyc - req_cyc), 64'(NB + 2));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_reissue", 64'(mem_req_valid), 64'd0);
        end

        // Fresh request: stalled ready, 3-cycle responses, miss address changed mid-fill.
        ready_mode = 1;
        lat        = 3;
        salt       = 32'h2000_0000;
        s0         = n_sent;
        r0         = n_resolved;
        @(posedge clk);
        #1;
        start_fill(32'h0000_5A44);
        repeat (6) @(posedge clk);
        #1;
        missed_addr = 32'h1234_5678;
        finish_fill(0);
        check("sent_once", 64'(n_sent - s0), 64'd1);
        check("resolved_once", 64'(n_resolved - r0), 64'd1);

        // Spurious responses in IDLE and in FETCH with nothing outstanding.
        @(negedge clk);
        lat        = 1;
        ready_mode = 2;
        spur       = 1'b1;
        salt       = 32'h3000_0000;
        repeat (4) @(negedge clk);
        start_fill(32'h0000_2210);
        repeat (4) @(negedge clk);
        check("stalled_req_valid", 64'(mem_req_valid), 64'd1);
        spur       = 1'b0;
        ready_mode = 0;
        finish_fill(0);

        // Reset after beat 10, then a new fill from the first edge with reset high.
        @(negedge clk);
        salt = 32'h4000_0000;
        start_fill(32'h0000_3380);
        base_resp = resp_cnt;
        found     = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = (resp_cnt >= base_resp + 10);
        end
        check("beat10_reached", 64'(found), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midfill");
        read_repair_request = 1'b0;
        mem_q.delete();
        exp_addr_q.delete();
        exp_blk_q.delete();
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        salt = 32'h5000_0000;
        start_fill(32'h0000_1004);
        @(posedge clk);
        #1;
        check("first_edge_accept", 64'(mem_req_valid), 64'd1);
        finish_fill(0);

        repeat (3) @(negedge clk);
        check("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
        check("blk_q_drained", 64'(exp_blk_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
